// File: rtl/gtx_tx_sched.sv
// Purpose: round-robin scheduler sharing one GTX TX lane between NREQ requesters, framing HDR+payload, comma idles.
// Latency: a word chosen in cycle t is registered onto gt0_txdata/gt0_txcharisk at t+1.
// Backpressure: REQ_READY is combinational; a stalled granted requester yields STALL words, never a timeout.
//
// Ports:
//   CLK, RST_N         lane user clock (rising edge), asynchronous active-low reset
//   EN                 grants allowed when 1; when 0 the current packet finishes, then idles only
//   REQ_VALID/READY    per-requester valid and same-cycle acceptance
//   REQ_DATA           packed payload words, requester i on [32*i +: 32]
//   gt0_txdata/charisk registered TX word and K flags to the GTX wrapper
//   BUSY               high while a packet payload is in progress
module gtx_tx_sched #(
    parameter int          NREQ         = 2,
    parameter int          PKT_WORDS    = 4,
    parameter int          ALIGN_PERIOD = 256,
    parameter logic [7:0]  COMMA        = 8'hBC
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic [NREQ-1:0]     REQ_VALID,
    input  logic [32*NREQ-1:0]  REQ_DATA,
    output logic [NREQ-1:0]     REQ_READY,
    output logic [31:0]         gt0_txdata,
    output logic [3:0]          gt0_txcharisk,
    output logic                BUSY
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int AW = $clog2(ALIGN_PERIOD + 1);

    localparam logic [31:0] IDLE_WORD  = {8'h00, 8'h00, COMMA, COMMA};
    localparam logic [31:0] STALL_WORD = {8'h00, 8'h00, 8'h7C, COMMA};
    localparam logic [3:0]  K_CTRL     = 4'b0011;

    typedef enum logic {ST_ARB, ST_PAYLOAD} state_e;
    typedef enum logic [1:0] {W_IDLE, W_HDR, W_STALL, W_DATA} word_e;

    state_e          state_q, state_d;
    logic [7:0]      seq_q, seq_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   g_q, g_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acnt_q, acnt_d;
    logic            pend_q, pend_d;
    logic [31:0]     txdata_q, txdata_d;
    logic [3:0]      txk_q, txk_d;

    word_e           word;
    logic            pend_clr;

    // Round-robin pick: rotate requests so the rr pointer sits at bit 0, take the
    // lowest set bit, then rotate the offset back into a requester index.
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [GW-1:0]     off;
    logic [GW:0]       sum;
    logic              pick_vld;
    logic [GW-1:0]     pick;

    always_comb begin
        dbl      = {REQ_VALID, REQ_VALID} >> rr_q;
        rot      = dbl[NREQ-1:0];
        off      = '0;
        pick_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_vld = 1'b1;
                off      = GW'(k);
            end
        end
        sum = {1'b0, rr_q} + {1'b0, off};
        if (sum >= (GW+1)'(NREQ)) begin
            sum = sum - (GW+1)'(NREQ);
        end
        pick = sum[GW-1:0];
    end

    // Only the granted requester's valid/data reach the datapath.
    logic        gnt_vld;
    logic [31:0] gnt_dat;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_q == GW'(i)) begin
                gnt_vld = REQ_VALID[i];
                gnt_dat = REQ_DATA[32*i +: 32];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_ARB;
            seq_q    <= '0;
            rr_q     <= '0;
            g_q      <= '0;
            cnt_q    <= '0;
            acnt_q   <= '0;
            pend_q   <= 1'b0;
            txdata_q <= IDLE_WORD;
            txk_q    <= K_CTRL;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            rr_q     <= rr_d;
            g_q      <= g_d;
            cnt_q    <= cnt_d;
            acnt_q   <= acnt_d;
            pend_q   <= pend_d;
            txdata_q <= txdata_d;
            txk_q    <= txk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        rr_d      = rr_q;
        g_d       = g_q;
        cnt_d     = cnt_q;
        word      = W_IDLE;
        pend_clr  = 1'b0;
        REQ_READY = '0;

        case (state_q)
            ST_ARB: begin
                // A pending alignment idle wins over any request.
                if (pend_q) begin
                    word     = W_IDLE;
                    pend_clr = 1'b1;
                end else if (EN && pick_vld) begin
                    word    = W_HDR;
                    g_d     = pick;
                    seq_d   = seq_q + 8'd1;
                    cnt_d   = '0;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (gnt_vld) begin
                    word = W_DATA;
                    for (int i = 0; i < NREQ; i++) begin
                        REQ_READY[i] = (g_q == GW'(i));
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(PKT_WORDS - 1)) begin
                        state_d = ST_ARB;
                        rr_d    = (g_q == GW'(NREQ - 1)) ? '0 : g_q + 1'b1;
                    end
                end else begin
                    word = W_STALL;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Output word mux; the header carries the requester picked this cycle.
    always_comb begin
        txdata_d = IDLE_WORD;
        txk_d    = K_CTRL;
        case (word)
            W_HDR:   txdata_d = {seq_q, 4'h5, 4'(pick), 8'h5C, COMMA};
            W_STALL: txdata_d = STALL_WORD;
            W_DATA: begin
                txdata_d = gnt_dat;
                txk_d    = 4'b0000;
            end
            default: txdata_d = IDLE_WORD;
        endcase
    end

    // Cycles since the last idle word, saturating; reaching the period arms a
    // forced idle that is only honoured (and cleared) in ARB.
    always_comb begin
        if (word == W_IDLE) begin
            acnt_d = '0;
        end else if (acnt_q == AW'(ALIGN_PERIOD)) begin
            acnt_d = acnt_q;
        end else begin
            acnt_d = acnt_q + 1'b1;
        end
        pend_d = (pend_q && !pend_clr) || (acnt_d == AW'(ALIGN_PERIOD));
    end

    assign gt0_txdata    = txdata_q;
    assign gt0_txcharisk = txk_q;
    assign BUSY          = (state_q == ST_PAYLOAD);

endmodule

// File: tb/tb_gtx_tx_sched.sv
// Purpose: randomized bench for gtx_tx_sched with a packet-level reference model and scoreboard.
// Latency: expected TX words are queued when stimulus is applied and popped one clock later.
// Backpressure: REQ_READY and BUSY are compared combinationally each cycle against the model.
module tb_gtx_tx_sched;

    localparam int NREQ = 3;
    localparam int PKT  = 4;
    localparam int AP   = 16;

    localparam logic [31:0] IDLE_W  = 32'h0000BCBC;
    localparam logic [31:0] STALL_W = 32'h00007CBC;

    logic                CLK = 1'b0;
    logic                RST_N = 1'b1;
    logic                EN = 1'b0;
    logic [NREQ-1:0]     REQ_VALID = '0;
    logic [32*NREQ-1:0]  REQ_DATA = '0;
    logic [NREQ-1:0]     REQ_READY;
    logic [31:0]         gt0_txdata;
    logic [3:0]          gt0_txcharisk;
    logic                BUSY;

    gtx_tx_sched #(
        .NREQ(NREQ), .PKT_WORDS(PKT), .ALIGN_PERIOD(AP), .COMMA(8'hBC)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN),
        .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
        .gt0_txdata(gt0_txdata), .gt0_txcharisk(gt0_txcharisk), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  k;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a packet is "in flight" with a number of payload words
    // still owed by requester m_g; m_since counts words since the last idle.
    bit m_in_pkt;
    bit m_due;
    int m_g, m_rr, m_seq, m_left, m_since;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_in_pkt = 0; m_due = 0;
        m_g = 0; m_rr = 0; m_seq = 0; m_left = 0; m_since = 0;
    endtask

    task automatic model_step(input logic [NREQ-1:0] v, input logic [32*NREQ-1:0] d,
                              input logic en, output exp_t e);
        bit idle;
        int k;
        idle = 0;
        e.w  = IDLE_W;
        e.k  = 4'b0011;
        if (!m_in_pkt) begin
            if (m_due) begin
                m_due = 0;
                idle  = 1;
            end else if (en && v != '0) begin
                k = 0;
                while (!v[(m_rr + k) % NREQ]) k++;
                m_g      = (m_rr + k) % NREQ;
                e.w      = {m_seq[7:0], 4'h5, 4'(m_g), 8'h5C, 8'hBC};
                e.k      = 4'b0011;
                m_seq    = (m_seq + 1) % 256;
                m_left   = PKT;
                m_in_pkt = 1;
            end else begin
                idle = 1;
            end
        end else if (v[m_g]) begin
            e.w    = d[32*m_g +: 32];
            e.k    = 4'b0000;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_in_pkt = 0;
                m_rr     = (m_g + 1) % NREQ;
            end
        end else begin
            e.w = STALL_W;
            e.k = 4'b0011;
        end
        if (idle) begin
            e.w     = IDLE_W;
            e.k     = 4'b0011;
            m_since = 0;
        end else begin
            m_since = (m_since < AP) ? m_since + 1 : AP;
            if (m_since == AP) m_due = 1;
        end
    endtask

    // One clock of stimulus: drive after the edge, check combinational outputs
    // and queue the expected registered word at the falling edge.
    task automatic cycle(input logic [NREQ-1:0] v, input logic en, input logic rstn);
        logic [32*NREQ-1:0] d;
        logic [NREQ-1:0]    exp_rdy;
        exp_t               e;
        @(posedge CLK);
        #2;
        for (int i = 0; i < NREQ; i++) d[32*i +: 32] = $urandom;
        REQ_VALID = v;
        REQ_DATA  = d;
        EN        = en;
        RST_N     = rstn;
        @(negedge CLK);
        if (!rstn) begin
            model_reset();
            exp_q.delete();
            chk("rst_txdata", gt0_txdata, IDLE_W);
            chk("rst_txk", gt0_txcharisk, 4'b0011);
            chk("rst_ready", REQ_READY, '0);
            chk("rst_busy", BUSY, 1'b0);
        end else begin
            exp_rdy = '0;
            if (m_in_pkt && v[m_g]) exp_rdy[m_g] = 1'b1;
            chk("req_ready", REQ_READY, exp_rdy);
            chk("busy", BUSY, m_in_pkt);
            model_step(v, d, en, e);
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [NREQ-1:0] rand_valid(input int pct);
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = ($urandom_range(99) < pct);
        return v;
    endfunction

    // Monitor: every registered output word is compared with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("txdata", gt0_txdata, e.w);
                chk("txcharisk", gt0_txcharisk, e.k);
            end
        end
    end

    initial begin
        model_reset();
        #1 RST_N = 1'b0;
        for (int i = 0; i < 4; i++) cycle('0, 1'b1, 1'b0);
        // Idle lane with nothing requested.
        for (int i = 0; i < 10; i++) cycle('0, 1'b1, 1'b1);
        // Single requester, one clean packet.
        for (int i = 0; i < 8; i++) cycle(3'b001, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle('0, 1'b1, 1'b1);
        // Stall in the middle of a packet.
        cycle(3'b010, 1'b1, 1'b1);
        cycle(3'b010, 1'b1, 1'b1);
        cycle(3'b010, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(3'b101, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(3'b010, 1'b1, 1'b1);
        // Random request patterns.
        for (int i = 0; i < 600; i++) cycle(rand_valid(70), 1'b1, 1'b1);
        // Everyone always valid: round robin, forced idles, SEQ wrap.
        for (int i = 0; i < 1800; i++) cycle('1, 1'b1, 1'b1);
        // Enable toggling with random requests.
        for (int i = 0; i < 300; i++) cycle(rand_valid(60), ($urandom_range(7) != 0), 1'b1);
        // EN dropped right after a header: packet completes, then idle only.
        cycle('1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle('1, 1'b0, 1'b1);
        // Reset in the middle of a packet.
        for (int i = 0; i < 7; i++) cycle('1, 1'b1, 1'b1);
        cycle('1, 1'b1, 1'b0);
        cycle('1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle('1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1);
        @(posedge CLK);
        #3;
        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
